dbg_commit_sched: RTL and testbench

//  Sequences per-instruction commit information from the core into the single-port

---
 rtl/dbg_commit_sched.sv | 215 +++++++++++++++++++++
 tb/tb_dbg_commit_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_commit_sched.sv
// Commit trace scheduler: buffers core commits in a FIFO and serializes each one
// into PC / GPR / CSR / EVENT trace records, and runs the halt sequence on ebreak/invalid.
module dbg_commit_sched #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_inst,
    input  logic        commit_brk,
    input  logic        commit_ivd,
    input  logic        gpr_wen,
    input  logic [31:0] gpr_waddr,
    input  logic [31:0] gpr_wdata,
    input  logic        csr_wen,
    input  logic [31:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    output logic        commit_stall,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [1:0]  trc_kind,
    output logic [31:0] trc_addr,
    output logic [31:0] trc_data,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic        overflow
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        brk;
        logic        ivd;
        logic        gwen;
        logic [31:0] gaddr;
        logic [31:0] gdata;
        logic        cwen;
        logic [31:0] caddr;
        logic [31:0] cdata;
    } entry_t;

    typedef enum logic [2:0] {StIdle, StPc, StGpr, StCsr, StEvt} state_e;

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic            halt_req_q, halted_q, overflow_q;
    logic [1:0]      cause_q;
    logic            push, pop, accept, full, head_evt, more;
    logic [1:0]      head_cause;

    assign full         = (count_q == CntW'(DEPTH));
    assign commit_stall = full | halt_req_q;
    assign push         = commit_valid & ~commit_stall;
    assign head         = mem_q[rptr_q];
    assign head_evt     = head.brk | head.ivd;
    assign head_cause   = head.brk ? 2'd1 : (head.ivd ? 2'd2 : 2'd0);
    assign accept       = trc_valid & trc_ready;
    // Another entry will be at the head after popping the current one.
    assign more         = (count_q > CntW'(1)) | push;
    assign count_d      = count_q + CntW'(push) - CntW'(pop);

    assign halted     = halted_q;
    assign halt_cause = cause_q;
    assign overflow   = overflow_q;

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = commit_pc;
        wr_entry.inst  = commit_inst;
        wr_entry.brk   = commit_brk;
        wr_entry.ivd   = commit_ivd;
        // x0 writes carry no architectural effect, so they are not traced.
        wr_entry.gwen  = gpr_wen & (gpr_waddr != '0);
        wr_entry.gaddr = gpr_waddr;
        wr_entry.gdata = gpr_wdata;
        wr_entry.cwen  = csr_wen;
        wr_entry.caddr = csr_waddr;
        wr_entry.cdata = csr_wdata;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            halt_req_q <= 1'b0;
            cause_q    <= 2'd0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            count_q <= count_d;
            if (push && (commit_brk || commit_ivd) && !halt_req_q) begin
                halt_req_q <= 1'b1;
                cause_q    <= commit_brk ? 2'd1 : 2'd2;
            end
            if (halt_req_q && (count_q == '0) && (state_q == StIdle)) begin
                halted_q <= 1'b1;
            end
            if (commit_valid && commit_stall) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next record for the head entry; skipped records cost no cycles.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if ((count_q != '0) || push) state_d = StPc;
            end
            StPc: begin
                if (accept) begin
                    if (head.gwen)      state_d = StGpr;
                    else if (head.cwen) state_d = StCsr;
                    else if (head_evt)  state_d = StEvt;
                    else begin
                        pop     = 1'b1;
                        state_d = more ? StPc : StIdle;
                    end
                end
            end
            StGpr: begin
                if (accept) begin
                    if (head.cwen)     state_d = StCsr;
                    else if (head_evt) state_d = StEvt;
                    else begin
                        pop     = 1'b1;
                        state_d = more ? StPc : StIdle;
                    end
                end
            end
            StCsr: begin
                if (accept) begin
                    if (head_evt) state_d = StEvt;
                    else begin
                        pop     = 1'b1;
                        state_d = more ? StPc : StIdle;
                    end
                end
            end
            StEvt: begin
                if (accept) begin
                    pop     = 1'b1;
                    state_d = more ? StPc : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        trc_valid = 1'b0;
        trc_kind  = 2'd0;
        trc_addr  = '0;
        trc_data  = '0;
        case (state_q)
            StPc: begin
                trc_valid = 1'b1;
                trc_kind  = 2'd0;
                trc_addr  = head.pc;
                trc_data  = head.inst;
            end
            StGpr: begin
                trc_valid = 1'b1;
                trc_kind  = 2'd1;
                trc_addr  = head.gaddr;
                trc_data  = head.gdata;
            end
            StCsr: begin
                trc_valid = 1'b1;
                trc_kind  = 2'd2;
                trc_addr  = head.caddr;
                trc_data  = head.cdata;
            end
            StEvt: begin
                trc_valid = 1'b1;
                trc_kind  = 2'd3;
                trc_addr  = {30'd0, head_cause};
                trc_data  = head.pc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dbg_commit_sched.sv
// Scoreboard bench for dbg_commit_sched: stimulus pushes expected trace records,
// a negedge monitor pops and compares every accepted record.
module tb_dbg_commit_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic [31:0] commit_inst = '0;
    logic        commit_brk = 1'b0;
    logic        commit_ivd = 1'b0;
    logic        gpr_wen = 1'b0;
    logic [31:0] gpr_waddr = '0;
    logic [31:0] gpr_wdata = '0;
    logic        csr_wen = 1'b0;
    logic [31:0] csr_waddr = '0;
    logic [31:0] csr_wdata = '0;
    logic        commit_stall;
    logic        trc_valid;
    logic        trc_ready = 1'b0;
    logic [1:0]  trc_kind;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;
    logic        halted;
    logic [1:0]  halt_cause;
    logic        overflow;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    dbg_commit_sched #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .commit_brk   (commit_brk),
        .commit_ivd   (commit_ivd),
        .gpr_wen      (gpr_wen),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata),
        .csr_wen      (csr_wen),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .commit_stall (commit_stall),
        .trc_valid    (trc_valid),
        .trc_ready    (trc_ready),
        .trc_kind     (trc_kind),
        .trc_addr     (trc_addr),
        .trc_data     (trc_data),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [1:0] kind, input logic [31:0] addr,
                            input logic [31:0] data);
        rec_t r;
        r.kind = kind;
        r.addr = addr;
        r.data = data;
        exp_q.push_back(r);
    endtask

    // Drives one commit for a single cycle; acc says whether the model expects it stored.
    task automatic commit(input logic [31:0] pc, input logic [31:0] inst,
                          input logic brk, input logic ivd,
                          input logic gw, input logic [31:0] ga, input logic [31:0] gd,
                          input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                          input bit acc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_inst  = inst;
        commit_brk   = brk;
        commit_ivd   = ivd;
        gpr_wen      = gw;
        gpr_waddr    = ga;
        gpr_wdata    = gd;
        csr_wen      = cw;
        csr_waddr    = ca;
        csr_wdata    = cd;
        if (acc) begin
            push_rec(2'd0, pc, inst);
            if (gw && ga != 32'd0) push_rec(2'd1, ga, gd);
            if (cw) push_rec(2'd2, ca, cd);
            if (brk || ivd) push_rec(2'd3, brk ? 32'd1 : 32'd2, pc);
        end
        step();
        commit_valid = 1'b0;
        commit_brk   = 1'b0;
        commit_ivd   = 1'b0;
        gpr_wen      = 1'b0;
        csr_wen      = 1'b0;
    endtask

    task automatic pc_only(input logic [31:0] pc, input bit acc);
        commit(pc, 32'h00000013, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, acc);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && trc_valid; i++) step();
        chk("drain_idle", {31'd0, trc_valid}, 32'd0);
    endtask

    task automatic do_reset();
        trc_ready = 1'b0;
        reset     = 1'b1;
        step();
        exp_q.delete();
        reset = 1'b0;
    endtask

    // Monitor: every accepted record must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && trc_valid && trc_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rec", {30'd0, trc_kind}, 32'hFFFFFFFF);
            end else begin
                rec_t r;
                r = exp_q.pop_front();
                chk("rec_kind", {30'd0, trc_kind}, {30'd0, r.kind});
                chk("rec_addr", trc_addr, r.addr);
                chk("rec_data", trc_data, r.data);
            end
        end
    end

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_valid", {31'd0, trc_valid}, 32'd0);
        chk("rst_stall", {31'd0, commit_stall}, 32'd0);
        chk("rst_kaddr", trc_addr | trc_data | {30'd0, trc_kind}, 32'd0);
        chk("rst_halt", {29'd0, halted, halt_cause}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        // 1: single commit with GPR write, one-cycle latency
        trc_ready = 1'b1;
        commit(32'h80000000, 32'h00100093, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, 1'b0, '0, '0, 1'b1);
        chk("t1_pc_valid", {31'd0, trc_valid}, 32'd1);
        chk("t1_pc_kind", {30'd0, trc_kind}, 32'd0);
        step();
        chk("t1_gpr_kind", {30'd0, trc_kind}, 32'd1);
        step();
        chk("t1_idle", {31'd0, trc_valid}, 32'd0);

        // 2: PC, GPR, CSR back to back; then x0 suppression
        commit(32'h80000004, 32'h00a00293, 1'b0, 1'b0, 1'b1, 32'd5, 32'hA,
               1'b1, 32'h300, 32'h1800, 1'b1);
        chk("t2_k0", {30'd0, trc_kind}, 32'd0);
        step();
        chk("t2_k1", {30'd0, trc_kind}, 32'd1);
        step();
        chk("t2_k2", {30'd0, trc_kind}, 32'd2);
        step();
        chk("t2_idle", {31'd0, trc_valid}, 32'd0);
        commit(32'h80000008, 32'h30029073, 1'b0, 1'b0, 1'b1, 32'd0, 32'h55,
               1'b1, 32'h300, 32'h1800, 1'b1);
        chk("t2b_k0", {30'd0, trc_kind}, 32'd0);
        step();
        chk("t2b_k2", {30'd0, trc_kind}, 32'd2);
        step();
        chk("t2b_idle", {31'd0, trc_valid}, 32'd0);

        // 3: fill FIFO with sink stalled
        trc_ready = 1'b0;
        for (int i = 0; i < 4; i++) pc_only(32'h80000100 + 32'(i * 4), 1'b1);
        chk("t3_full_stall", {31'd0, commit_stall}, 32'd1);
        step();
        chk("t3_hold_stall", {31'd0, commit_stall}, 32'd1);
        trc_ready = 1'b1;
        step();
        chk("t3_stall_drop", {31'd0, commit_stall}, 32'd0);
        pc_only(32'h80000110, 1'b1);
        wait_idle();

        // 6: reset during GPR record with 3 entries queued
        trc_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            commit(32'h80000200 + 32'(i * 4), 32'h00100093, 1'b0, 1'b0,
                   1'b1, 32'd1, 32'(i), 1'b0, '0, '0, 1'b1);
        trc_ready = 1'b1;
        step();
        chk("t6_in_gpr", {30'd0, trc_kind}, 32'd1);
        do_reset();
        chk("t6_rst_valid", {31'd0, trc_valid}, 32'd0);
        chk("t6_rst_stall", {31'd0, commit_stall}, 32'd0);
        trc_ready = 1'b1;
        pc_only(32'h80000300, 1'b1);
        chk("t6_lat_valid", {31'd0, trc_valid}, 32'd1);
        chk("t6_lat_addr", trc_addr, 32'h80000300);
        wait_idle();

        // 4: ebreak behind two queued entries
        trc_ready = 1'b0;
        pc_only(32'h80000008, 1'b1);
        pc_only(32'h8000000C, 1'b1);
        commit(32'h80000010, 32'h00100073, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        chk("t4_halt_stall", {31'd0, commit_stall}, 32'd1);
        trc_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t4_drained", {31'd0, trc_valid}, 32'd0);
        chk("t4_stall_held", {31'd0, commit_stall}, 32'd1);
        step();
        chk("t4_halted", {31'd0, halted}, 32'd1);
        chk("t4_cause", {30'd0, halt_cause}, 32'd1);

        // 5: commit while stalled is dropped and flagged
        chk("t5_ovf_before", {31'd0, overflow}, 32'd0);
        pc_only(32'h80000014, 1'b0);
        chk("t5_ovf", {31'd0, overflow}, 32'd1);
        step();
        step();
        chk("t5_no_rec", {31'd0, trc_valid}, 32'd0);
        chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
        do_reset();
        chk("t5_ovf_clr", {31'd0, overflow}, 32'd0);
        chk("t5_halt_clr", {31'd0, halted}, 32'd0);

        // 7: invalid instruction halt
        trc_ready = 1'b1;
        commit(32'h80000020, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        step();
        step();
        step();
        chk("t7_halted", {31'd0, halted}, 32'd1);
        chk("t7_cause", {30'd0, halt_cause}, 32'd2);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
